and_gate_sequencer: RTL and testbench
=====================================

# and_gate_sequencer

Self-checking stimulus controller for the registered 2-input AND gate unit (`a`, `b` in; `y` registered on `posedge clk`). On a start pulse it:

- drives the gate through all four input vectors, for a configurable number of passes;
- waits out the gate's register latency;
- compares the gate output against the expected AND;
- reports an error count, the first failing vector and a done/pass status.

It sits beside the gate as its only driver, as a built-in self-test sequencer.

## Interface
Parameters:
- `LAT`, default 1: gate latency in cycles from input change to valid `y`; must be ≥ 1.
- `NUM_PASSES`, default 1: number of full 4-vector sweeps per run; must be ≥ 1.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `y_in`  in  1  gate output `y`.
- `a_out`  out  1  gate input `a`; registered.
- `b_out`  out  1  gate input `b`; registered.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  last run had zero mismatches; valid from `done` until next start.
- `err_cnt`  out  ERR_W  mismatch count, saturating.
- `fail_valid`  out  1  at least one mismatch has occurred in the current or last run.
- `fail_vec`  out  2  `{a,b}` of the first mismatching vector.

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- Vector order is 00, 01, 10, 11, with `{a_out,b_out}` equal to the 2-bit vector index.
- Internal counters:
  - 2-bit vector index;
  - pass counter of width `$clog2(NUM_PASSES+1)`;
  - latency counter of width `$clog2(LAT+1)`.
- **IDLE**
  - `a_out = b_out = 0`, `busy = 0`.
  - When `start = 1` at an edge, the sequencer:
    - clears `err_cnt`, `fail_valid`, `fail_vec` and `pass`;
    - loads vector 0 onto `a_out`/`b_out`;
    - loads the latency counter with `LAT`;
    - moves to APPLY.
- **APPLY**
  - Holds the vector; the latency counter decrements each cycle.
  - Goes to CHECK at the edge where the counter reaches 0, i.e. after exactly `LAT` cycles in APPLY.
- **CHECK** (one cycle): at its closing edge, compare `y_in` against `a_out & b_out`.
  - On mismatch, `err_cnt` increments, saturating at `2^ERR_W - 1`.
  - On the first mismatch of the run, `fail_vec <= {a_out,b_out}` and `fail_valid <= 1`; later mismatches do not change `fail_vec`.
  - If the vector is not 11: advance the vector, reload the latency counter, go to APPLY.
  - If the vector is 11 and this is not the last pass: wrap the vector to 00, increment the pass counter, go to APPLY.
  - If the vector is 11 and this is the last pass: go to DONE, and drive `a_out = b_out = 0`.
- **DONE** (one cycle)
  - `done = 1`; `pass = (err_cnt == 0)`.
  - Goes to IDLE unconditionally.
  - `start` is ignored while in DONE.
- `start` is also ignored in APPLY and CHECK; there is no restart and no queueing.
- Status holding:
  - `err_cnt`, `fail_vec`, `fail_valid` and `pass` hold their values in IDLE until the next accepted start.
  - The mismatch comparison counts saturated errors correctly, but `pass` is derived only from `err_cnt`. A saturated counter is therefore never 0, so `pass` stays 0.

## Timing
- Reset values (asynchronous): state IDLE, `a_out = b_out = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_cnt = 0`, `fail_valid = 0`, `fail_vec = 00`, all internal counters 0.
- `rst` asserted mid-run aborts immediately:
  - no `done` pulse;
  - the gate inputs are forced to 0;
  - operation resumes in IDLE after `rst` is deasserted.
- Let edge E0 be the edge at which `start` is accepted.
  - `a_out`/`b_out` carry vector 0 after E0.
  - Each vector occupies `LAT + 1` cycles.
  - The final CHECK edge is E(4·NUM_PASSES·(LAT+1)).
  - `done` is high for the cycle that follows that edge.
- `busy` is 1 in APPLY and CHECK. It rises after E0 and falls together with the rise of `done`.
- The `y_in` sample point is `LAT + 1` edges after the vector changes. This matches the `LAT`-cycle gate register with one cycle of margin for the `a_out` register.
- All outputs are registered; no output has a combinational path from `start` or `y_in`.

## Test plan
All scenarios use `LAT = 1`.

1. **Correct gate, defaults**
   - Stimulus: `start` pulsed at edge E0.
   - Required: `{a_out,b_out}` steps 00, 01, 10, 11 every 2 cycles; `done` is high in the cycle after E8; `pass = 1`; `err_cnt = 0`; `fail_valid = 0`; `busy` is high for exactly 8 cycles.
2. **Gate stuck-at-0** (`y_in` tied to 0)
   - Required: `err_cnt = 1`, `fail_vec = 11`, `fail_valid = 1`, `pass = 0`.
3. **Gate stuck-at-1, `NUM_PASSES = 2`**
   - Required: `err_cnt = 6`, `fail_vec = 00`, `done` in the cycle after E16, `pass = 0`.
4. **Saturation: `ERR_W = 2`, `NUM_PASSES = 3`, stuck-at-1** (9 mismatches)
   - Required: `err_cnt = 3`, `pass = 0`.
5. **`start` held high throughout, correct gate**
   - Required: the run is not restarted mid-run; `done` pulses every 10 cycles (8 busy, DONE, IDLE re-accept); `err_cnt` is cleared at each accepted start.
6. **`rst` asserted during APPLY of vector 10**
   - Required: all outputs return to their reset values asynchronously; no `done` pulse; the next start runs a full clean sweep with `pass = 1`.

Source files
------------

// File: rtl/and_gate_sequencer.sv
// Built-in self-test sequencer for a registered 2-input AND gate: sweeps all
// four input vectors, checks the gate output after its latency, reports status.
module and_gate_sequencer #(
  parameter int LAT        = 1,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int LW = $clog2(LAT + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       vec, vec_n;
  logic [PW-1:0]    pass_cnt, pass_cnt_n;
  logic [LW-1:0]    lat_cnt, lat_cnt_n;
  logic             a_n, b_n, busy_n, done_n, pass_n, fail_valid_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic [1:0]       fail_vec_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      lat_cnt    <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      pass_cnt   <= pass_cnt_n;
      lat_cnt    <= lat_cnt_n;
      a_out      <= a_n;
      b_out      <= b_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_cnt_n;
      fail_valid <= fail_valid_n;
      fail_vec   <= fail_vec_n;
    end
  end

  always_comb begin
    state_n      = state;
    vec_n        = vec;
    pass_cnt_n   = pass_cnt;
    lat_cnt_n    = lat_cnt;
    a_n          = a_out;
    b_n          = b_out;
    pass_n       = pass;
    err_cnt_n    = err_cnt;
    fail_valid_n = fail_valid;
    fail_vec_n   = fail_vec;

    case (state)
      IDLE: begin
        a_n = 1'b0;
        b_n = 1'b0;
        if (start) begin
          err_cnt_n    = '0;
          fail_valid_n = 1'b0;
          fail_vec_n   = '0;
          pass_n       = 1'b0;
          vec_n        = '0;
          pass_cnt_n   = '0;
          lat_cnt_n    = LW'(LAT);
          state_n      = APPLY;
        end
      end

      APPLY: begin
        // Leave on the edge where the counter hits zero: LAT cycles in APPLY.
        if (lat_cnt <= LW'(1)) begin
          lat_cnt_n = '0;
          state_n   = CHECK;
        end else begin
          lat_cnt_n = lat_cnt - LW'(1);
        end
      end

      CHECK: begin
        if (y_in != (a_out & b_out)) begin
          if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid_n = 1'b1;
            fail_vec_n   = {a_out, b_out};
          end
        end
        if (vec != 2'b11) begin
          vec_n        = vec + 2'd1;
          {a_n, b_n}   = vec + 2'd1;
          lat_cnt_n    = LW'(LAT);
          state_n      = APPLY;
        end else if (pass_cnt != PW'(NUM_PASSES - 1)) begin
          vec_n        = '0;
          {a_n, b_n}   = 2'b00;
          pass_cnt_n   = pass_cnt + PW'(1);
          lat_cnt_n    = LW'(LAT);
          state_n      = APPLY;
        end else begin
          a_n     = 1'b0;
          b_n     = 1'b0;
          pass_n  = (err_cnt_n == '0);
          state_n = DONE;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    busy_n = (state_n == APPLY) || (state_n == CHECK);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_and_gate_sequencer.sv
// Randomized self-checking bench: four sequencer configurations, each driving a
// behavioural gate model with an injectable per-vector fault mask.
module tb_and_gate_sequencer;

  function automatic int lat_of(input int g);
    return (g == 3) ? 3 : 1;
  endfunction
  function automatic int passes_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 2;
  endfunction
  function automatic int errw_of(input int g);
    return (g == 2) ? 2 : (g == 3) ? 3 : 4;
  endfunction

  logic       clk = 1'b0;
  logic [3:0] rst = 4'hF;
  logic [3:0] start = 4'h0;
  logic [3:0] y;
  logic [3:0] a_o, b_o, busy, done, pass_o, fail_valid;
  logic [1:0] fail_vec [4];
  logic [3:0] err_x [4];
  logic [3:0] mask [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int L = lat_of(g);
    localparam int P = passes_of(g);
    localparam int W = errw_of(g);
    logic [W-1:0] e;
    logic [L:0]   pipe = '0;

    // Gate model: L-stage registered AND, output inverted on masked vectors.
    always @(posedge clk)
      pipe <= {pipe[L-1:0], (a_o[g] & b_o[g]) ^ mask[g][{a_o[g], b_o[g]}]};
    assign y[g] = pipe[L-1];
    assign err_x[g] = 4'(e);

    and_gate_sequencer #(.LAT(L), .NUM_PASSES(P), .ERR_W(W)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .start      (start[g]),
      .y_in       (y[g]),
      .a_out      (a_o[g]),
      .b_out      (b_o[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass_o[g]),
      .err_cnt    (e),
      .fail_valid (fail_valid[g]),
      .fail_vec   (fail_vec[g])
    );
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int g, input string tag);
    check({tag, "_ab"}, {a_o[g], b_o[g]}, 0);
    check({tag, "_busy"}, busy[g], 0);
    check({tag, "_done"}, done[g], 0);
    check({tag, "_pass"}, pass_o[g], 0);
    check({tag, "_err"}, err_x[g], 0);
    check({tag, "_fvalid"}, fail_valid[g], 0);
    check({tag, "_fvec"}, fail_vec[g], 0);
  endtask

  // One pulsed run, checked cycle by cycle against the expected sweep.
  task automatic run(input int g, input logic [3:0] m);
    int L, P, W, N, nm, exp_err, exp_vec;
    L = lat_of(g); P = passes_of(g); W = errw_of(g);
    N = 4 * P * (L + 1);
    nm = P * $countones(m);
    exp_err = (nm > (1 << W) - 1) ? (1 << W) - 1 : nm;
    exp_vec = 0;
    for (int v = 3; v >= 0; v--) if (m[v]) exp_vec = v;
    mask[g] = m;
    @(negedge clk);
    check("busy_pre", busy[g], 0);
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check("vec", {a_o[g], b_o[g]}, (k / (L + 1)) % 4);
      check("busy", busy[g], 1);
      check("done_early", done[g], 0);
    end
    @(posedge clk); #1;
    check("done", done[g], 1);
    check("busy_end", busy[g], 0);
    check("ab_end", {a_o[g], b_o[g]}, 0);
    check("err_cnt", err_x[g], exp_err);
    check("fail_valid", fail_valid[g], (nm > 0) ? 1 : 0);
    check("fail_vec", fail_vec[g], exp_vec);
    check("pass", pass_o[g], (exp_err == 0) ? 1 : 0);
    @(posedge clk); #1;
    check("done_pulse", done[g], 0);
    check("err_hold", err_x[g], exp_err);
    check("pass_hold", pass_o[g], (exp_err == 0) ? 1 : 0);
  endtask

  task automatic wait_done(input int g, output int t);
    int n = 0;
    while (!done[g] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done[g], 1);
    t = cyc;
  endtask

  initial begin
    int t1, t2, t3, dn;
    #1;
    for (int g = 0; g < 4; g++) check_idle_outputs(g, "reset");
    repeat (2) @(negedge clk);
    rst = 4'h0;

    run(0, 4'b0000);   // correct gate
    run(0, 4'b1000);   // stuck-at-0
    run(1, 4'b0111);   // stuck-at-1, two passes
    run(2, 4'b0111);   // saturation
    repeat (12) run($urandom_range(0, 3), 4'($urandom_range(0, 15)));

    // start held high: back-to-back runs, status cleared at each start
    mask[0] = 4'b1000;
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, t1);
    check("held_err1", err_x[0], 1);
    mask[0] = 4'b0000;
    @(posedge clk); #1;
    wait_done(0, t2);
    check("held_period1", t2 - t1, 10);
    check("held_err2", err_x[0], 0);
    check("held_pass2", pass_o[0], 1);
    mask[0] = 4'b0111;
    @(posedge clk); #1;
    wait_done(0, t3);
    check("held_period2", t3 - t2, 10);
    check("held_err3", err_x[0], 3);
    start[0] = 1'b0;
    repeat (3) @(posedge clk);

    // asynchronous reset during APPLY of vector 10
    mask[0] = 4'b0001;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_vec", {a_o[0], b_o[0]}, 2);
    check("pre_rst_err", err_x[0], 1);
    #2 rst[0] = 1'b1;
    #1 check_idle_outputs(0, "async_rst");
    @(negedge clk);
    rst[0] = 1'b0;
    dn = 0;
    repeat (12) begin @(posedge clk); #1; dn += done[0]; end
    check("no_done_after_rst", dn, 0);
    run(0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
